// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider: FSM encoding and the ALU
// control codes that the ALU decodes into start/signed_div.
package div_iter_pkg;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_CALC = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   localparam logic [7:0] DIV_CONTROL  = 8'b0001_1010;
   localparam logic [7:0] DIVU_CONTROL = 8'b0001_1011;

endpackage

// File: rtl/div_iter_signfix.sv
// Conditional two's-complement negate; used both to take operand magnitudes
// and to restore the sign of quotient/remainder.
module div_iter_signfix #(
   parameter int W = 32
) (
   input  logic [W-1:0] val_i,
   input  logic         neg_i,
   output logic [W-1:0] val_o
);

   assign val_o = neg_i ? (-val_i) : val_i;

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle, with
// pipeline stall, annul and hold-until-accept of the {remainder, quotient}.
//
// state    | meaning
// DIV_IDLE | waiting for start
// DIV_CALC | one quotient bit per cycle, counter WIDTH..1
// DIV_DONE | result held until accept
module div_iter
   import div_iter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               signed_div,
   input  logic [WIDTH-1:0]   opa,
   input  logic [WIDTH-1:0]   opb,
   input  logic               annul,
   input  logic               accept,
   output logic               stall,
   output logic               ready,
   output logic               busy,
   output logic [2*WIDTH-1:0] result
);

   localparam int CW = $clog2(WIDTH + 1);

   div_state_e         state_q;
   logic [WIDTH:0]     rem_q;
   logic [WIDTH-1:0]   dvd_q;
   logic [WIDTH-1:0]   dvs_q;
   logic [CW-1:0]      cnt_q;
   logic               qneg_q;
   logic               rneg_q;
   logic               busy_q;
   logic               ready_q;
   logic [2*WIDTH-1:0] result_q;

   logic [WIDTH-1:0]   opa_abs;
   logic [WIDTH-1:0]   opb_abs;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic [WIDTH+1:0]   diff;
   logic               qbit;
   logic [WIDTH:0]     rem_d;
   logic [WIDTH-1:0]   dvd_d;

   div_iter_signfix #(.W(WIDTH)) u_abs_a (
      .val_i(opa), .neg_i(signed_div & opa[WIDTH-1]), .val_o(opa_abs)
   );
   div_iter_signfix #(.W(WIDTH)) u_abs_b (
      .val_i(opb), .neg_i(signed_div & opb[WIDTH-1]), .val_o(opb_abs)
   );

   // Dividend shifts out of the top of dvd_q while quotient bits enter at the bottom.
   assign diff  = {rem_q, dvd_q[WIDTH-1]} - {2'b00, dvs_q};
   assign qbit  = ~diff[WIDTH+1];
   assign rem_d = qbit ? diff[WIDTH:0] : {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
   assign dvd_d = {dvd_q[WIDTH-2:0], qbit};

   div_iter_signfix #(.W(WIDTH)) u_fix_q (
      .val_i(dvd_d), .neg_i(qneg_q), .val_o(quo_fix)
   );
   div_iter_signfix #(.W(WIDTH)) u_fix_r (
      .val_i(rem_d[WIDTH-1:0]), .neg_i(rneg_q), .val_o(rem_fix)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= DIV_IDLE;
         rem_q    <= '0;
         dvd_q    <= '0;
         dvs_q    <= '0;
         cnt_q    <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         busy_q   <= 1'b0;
         ready_q  <= 1'b0;
         result_q <= '0;
      end else if (annul) begin
         state_q <= DIV_IDLE;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         case (state_q)
            DIV_IDLE: begin
               if (start) begin
                  state_q <= DIV_CALC;
                  rem_q   <= '0;
                  dvd_q   <= opa_abs;
                  dvs_q   <= opb_abs;
                  cnt_q   <= CW'(WIDTH);
                  qneg_q  <= signed_div & (opa[WIDTH-1] ^ opb[WIDTH-1]);
                  rneg_q  <= signed_div & opa[WIDTH-1];
                  busy_q  <= 1'b1;
               end
            end
            DIV_CALC: begin
               rem_q <= rem_d;
               dvd_q <= dvd_d;
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_q  <= DIV_DONE;
                  busy_q   <= 1'b0;
                  ready_q  <= 1'b1;
                  result_q <= {rem_fix, quo_fix};
               end
            end
            DIV_DONE: begin
               if (accept) begin
                  state_q <= DIV_IDLE;
                  ready_q <= 1'b0;
               end
            end
            default: begin
               state_q <= DIV_IDLE;
               busy_q  <= 1'b0;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign stall  = ((state_q == DIV_IDLE) & start & ~annul) | (state_q == DIV_CALC);
   assign busy   = busy_q;
   assign ready  = ready_q;
   assign result = result_q;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: 32-bit and 8-bit instances, directed
// vectors, annul/reset/hold sequences and randomized checks against a model.
module tb_div_iter;

   logic        clk = 1'b0;
   logic        rst;
   logic        start32, start8, sd, annul, accept;
   logic [31:0] opa32, opb32;
   logic [7:0]  opa8, opb8;
   logic        stall32, ready32, busy32, stall8, ready8, busy8;
   logic [63:0] res32;
   logic [15:0] res8;

   int n_tests = 0;
   int n_fail  = 0;
   bit sel8 = 1'b0;

   logic        m_stall, m_busy, m_ready;
   logic [31:0] m_q, m_r;

   always #5 clk = ~clk;

   div_iter #(.WIDTH(32)) u_div32 (
      .clk(clk), .rst(rst), .start(start32), .signed_div(sd), .opa(opa32), .opb(opb32),
      .annul(annul), .accept(accept), .stall(stall32), .ready(ready32), .busy(busy32),
      .result(res32)
   );

   div_iter #(.WIDTH(8)) u_div8 (
      .clk(clk), .rst(rst), .start(start8), .signed_div(sd), .opa(opa8), .opb(opb8),
      .annul(annul), .accept(accept), .stall(stall8), .ready(ready8), .busy(busy8),
      .result(res8)
   );

   always_comb begin
      m_stall = stall32;
      m_busy  = busy32;
      m_ready = ready32;
      m_q     = res32[31:0];
      m_r     = res32[63:32];
      if (sel8) begin
         m_stall = stall8;
         m_busy  = busy8;
         m_ready = ready8;
         m_q     = {24'b0, res8[7:0]};
         m_r     = {24'b0, res8[15:8]};
      end
   end

   typedef struct {
      logic        s;
      logic [31:0] a, b, exp_q, exp_r;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic chk_b(input string name, input logic got, input logic exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, got, exp);
      end
   endtask

   task automatic chk_i(input string name, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Truncating division, remainder follows dividend, divide-by-zero gives
   // all-ones (or 1 for a negative signed dividend) with remainder = dividend.
   function automatic void ref_div(input int w, input logic s, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] q,
                                   output logic [31:0] r);
      longint m, ua, ub, sa, sb, lq, lr;
      bit neg_a, neg_b;
      m  = (longint'(1) << w) - 1;
      ua = longint'(a) & m;
      ub = longint'(b) & m;
      neg_a = s && (((ua >> (w - 1)) & 1) == 1);
      neg_b = s && (((ub >> (w - 1)) & 1) == 1);
      if (ub == 0) begin
         lr = ua;
         lq = neg_a ? 1 : m;
      end else if (!s) begin
         lq = ua / ub;
         lr = ua % ub;
      end else begin
         sa = neg_a ? ua - (m + 1) : ua;
         sb = neg_b ? ub - (m + 1) : ub;
         lq = sa / sb;
         lr = sa % sb;
      end
      q = 32'(lq & m);
      r = 32'(lr & m);
   endfunction

   function automatic logic [31:0] pick(input int w);
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'd1 << (w - 1);
         3:       return 32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   task automatic drive(input logic st, input logic [31:0] a, input logic [31:0] b);
      if (sel8) begin
         start8 = st;
         opa8   = a[7:0];
         opb8   = b[7:0];
      end else begin
         start32 = st;
         opa32   = a;
         opb32   = b;
      end
   endtask

   // Issue one division with start held as a level; operands wander after the
   // issue cycle. Holds DONE for 'hold' cycles before accepting.
   task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input int hold, output logic [31:0] q, output logic [31:0] r,
                          output int lat);
      int stalls;
      @(negedge clk);
      sd     = s;
      accept = 1'b0;
      drive(1'b1, a, b);
      #1;
      chk_b("stall_issue", m_stall, 1'b1);
      stalls = 1;
      lat    = 0;
      do begin
         @(negedge clk);
         lat++;
         drive(1'b1, $urandom, $urandom);
         sd = 1'($urandom);
         #1;
         if (!m_ready && m_stall) stalls++;
      end while (!m_ready && lat < 100);
      chk_b("ready_rise", m_ready, 1'b1);
      chk_i("stall_cycles", stalls, sel8 ? 9 : 33);
      q = m_q;
      r = m_r;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         drive(1'b1, $urandom, $urandom);
         #1;
         chk_b("hold_ready", m_ready, 1'b1);
         chk_b("hold_busy", m_busy, 1'b0);
         chk("hold_q", m_q, q);
         chk("hold_r", m_r, r);
      end
      @(negedge clk);
      accept = 1'b1;
      drive(1'b0, 32'd0, 32'd0);
      @(negedge clk);
      accept = 1'b0;
      #1;
      chk_b("idle_ready", m_ready, 1'b0);
      chk_b("idle_busy", m_busy, 1'b0);
   endtask

   vec_t vecs[9];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] q, r, eq, er, prev_q, prev_r;
      int          lat;
      bit          seen;
      logic        s;
      logic [31:0] a, b;

      vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
      vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
      vecs[2] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
      vecs[3] = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5};
      vecs[4] = '{1'b1, 32'hFFFF_FFFB,  32'd0,          32'd1,          32'hFFFF_FFFB};
      vecs[5] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
      vecs[6] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};
      vecs[7] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
      vecs[8] = '{1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5};

      rst = 1'b1; start32 = 1'b0; start8 = 1'b0; sd = 1'b0; annul = 1'b0; accept = 1'b0;
      opa32 = '0; opb32 = '0; opa8 = '0; opb8 = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk_b("rst_stall", stall32, 1'b0);
      chk_b("rst_busy", busy32, 1'b0);
      chk_b("rst_ready", ready32, 1'b0);
      chk("rst_res_lo", res32[31:0], 32'd0);
      chk("rst_res_hi", res32[63:32], 32'd0);
      chk_b("rst8_ready", ready8, 1'b0);

      for (int i = 0; i < 9; i++) begin
         run_div(vecs[i].s, vecs[i].a, vecs[i].b, 0, q, r, lat);
         chk($sformatf("vec%0d_q", i), q, vecs[i].exp_q);
         chk($sformatf("vec%0d_r", i), r, vecs[i].exp_r);
         chk_i($sformatf("vec%0d_lat", i), lat, 33);
      end
      prev_q = q;
      prev_r = r;

      // annul ten cycles into CALC
      @(negedge clk);
      sd = 1'b0;
      drive(1'b1, 32'd100, 32'd7);
      repeat (10) @(negedge clk);
      annul = 1'b1;
      drive(1'b0, 32'd0, 32'd0);
      #1;
      chk_b("annul_busy_before", busy32, 1'b1);
      @(negedge clk);
      annul = 1'b0;
      #1;
      chk_b("annul_busy", busy32, 1'b0);
      chk_b("annul_stall", stall32, 1'b0);
      chk_b("annul_ready", ready32, 1'b0);
      chk("annul_keep_q", res32[31:0], prev_q);
      chk("annul_keep_r", res32[63:32], prev_r);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         #1;
         if (ready32) seen = 1'b1;
      end
      chk_b("annul_no_ready", seen, 1'b0);

      // annul wins over start in the same cycle
      @(negedge clk);
      annul = 1'b1;
      drive(1'b1, 32'd9, 32'd3);
      #1;
      chk_b("annul_vs_start_stall", stall32, 1'b0);
      @(negedge clk);
      annul = 1'b0;
      drive(1'b0, 32'd0, 32'd0);
      #1;
      chk_b("annul_vs_start_busy", busy32, 1'b0);
      run_div(1'b0, 32'd9, 32'd3, 0, q, r, lat);
      chk("after_annul_q", q, 32'd3);
      chk("after_annul_r", r, 32'd0);

      // hold in DONE, then back-to-back issue
      run_div(1'b0, 32'd1000, 32'd9, 5, q, r, lat);
      chk("hold_res_q", q, 32'd111);
      chk("hold_res_r", r, 32'd1);
      run_div(1'b1, 32'hFFFF_FF9C, 32'd7, 0, q, r, lat);
      chk("b2b_q", q, 32'hFFFF_FFF2);
      chk("b2b_r", r, 32'hFFFF_FFFE);
      chk_i("b2b_lat", lat, 33);

      // reset mid-CALC clears everything
      @(negedge clk);
      sd = 1'b0;
      drive(1'b1, 32'd50, 32'd3);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      drive(1'b0, 32'd0, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_b("midrst_stall", stall32, 1'b0);
      chk_b("midrst_busy", busy32, 1'b0);
      chk_b("midrst_ready", ready32, 1'b0);
      chk("midrst_res_lo", res32[31:0], 32'd0);
      chk("midrst_res_hi", res32[63:32], 32'd0);

      // 8-bit instance
      sel8 = 1'b1;
      run_div(1'b0, 32'd200, 32'd13, 0, q, r, lat);
      chk("w8_q", q, 32'd15);
      chk("w8_r", r, 32'd5);
      chk_i("w8_lat", lat, 9);
      for (int i = 0; i < 20; i++) begin
         s = 1'($urandom);
         a = pick(8) & 32'hFF;
         b = pick(8) & 32'hFF;
         ref_div(8, s, a, b, eq, er);
         run_div(s, a, b, $urandom_range(0, 2), q, r, lat);
         chk($sformatf("w8_rand%0d_q s=%0b a=%h b=%h", i, s, a[7:0], b[7:0]), q, eq);
         chk($sformatf("w8_rand%0d_r", i), r, er);
         chk_i($sformatf("w8_rand%0d_lat", i), lat, 9);
      end

      sel8 = 1'b0;
      for (int i = 0; i < 40; i++) begin
         s = 1'($urandom);
         a = pick(32);
         b = pick(32);
         ref_div(32, s, a, b, eq, er);
         run_div(s, a, b, $urandom_range(0, 2), q, r, lat);
         chk($sformatf("w32_rand%0d_q s=%0b a=%h b=%h", i, s, a, b), q, eq);
         chk($sformatf("w32_rand%0d_r", i), r, er);
         chk_i($sformatf("w32_rand%0d_lat", i), lat, 33);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/div_iter.md
# div_iter

Parametrised iterative radix-2 integer divider for the EX stage of the five-stage pipeline, replacing the fixed 32-bit divider behind the HILO path. It accepts signed or unsigned WIDTH-bit operands, produces `{remainder, quotient}` in HILO layout, and drives a stall output that holds the pipeline while it iterates. It can be annulled mid-operation when an exception is taken in MEM. It holds its result until the pipeline confirms consumption.

## Interface

- Reset: one clock; reset is synchronous and active-high, ports `clk` and `rst`.

Parameters:
- `WIDTH`, 32, operand width; even, ≥ 4.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `start`  in  1  level request from the EX-stage instruction (DIV/DIVU decoded)
- `signed_div`  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with `start`
- `opa`  in  WIDTH  dividend; sampled with `start`
- `opb`  in  WIDTH  divisor; sampled with `start`
- `annul`  in  1  abort (exception in MEM); highest priority after `rst`
- `accept`  in  1  EX stage advances this cycle (`~stallE`); releases a held result
- `stall`  out  1  pipeline must hold EX (combinational)
- `ready`  out  1  result valid; qualifies HILO write
- `busy`  out  1  iteration in progress
- `result`  out  2*WIDTH  `{remainder, quotient}`; upper half to HI, lower half to LO

## Operation

- States:
  - IDLE: waiting for a request.
  - CALC: one quotient bit per cycle; iteration counter counts WIDTH down to 1.
  - DONE: result held.
- IDLE → CALC on `start & ~annul`:
  - Latch the absolute values of `opa`/`opb` (raw values if unsigned).
  - Latch sign flags: `qneg = signed & (opa[W-1] ^ opb[W-1])`, `rneg = signed & opa[W-1]`.
  - Clear the partial remainder (WIDTH+1 bits); load counter = WIDTH.
- CALC, each cycle:
  - Shift `{rem, dividend}` left by one and trial-subtract the divisor.
  - If no borrow, keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
  - Counter decrements.
- CALC → DONE when the counter reaches 1. On that edge the final bit is applied, `result` is written with sign fix-up (negate quotient if `qneg`, negate remainder if `rneg`), and `ready` rises.
- DONE → IDLE on `accept`. While DONE and `~accept`, `ready` stays 1, `result` is held, and no relaunch occurs.
- `annul` in any state → IDLE next edge. `ready` does not assert and `result` keeps its previous value. `annul` beats `start` in the same cycle.
- Outputs:
  - `stall = (state==IDLE & start & ~annul) | state==CALC`
  - `busy = state==CALC`
  - `ready = state==DONE`
- Boundary cases:
  - Divide by zero: no exception, full latency, algorithmic result.
    - Unsigned: quotient all-ones, remainder `opa`.
    - Signed: quotient 1 if `opa` < 0, else all-ones; remainder `opa`.
  - Signed MIN / −1: quotient MIN, remainder 0. No overflow flag.
  - Remainder sign always follows the dividend (truncating division).
- Reset: state IDLE, `result` = 0, `stall` = `busy` = `ready` = 0.

## Timing

- `start` sampled at cycle 0 edge → CALC during cycles 1..WIDTH → `ready` = 1 from cycle WIDTH+1.
- Stall spans cycles 0..WIDTH, i.e. WIDTH+1 cycles; WIDTH=32 gives 33 stall cycles.
- `result` is registered and valid in every cycle `ready` = 1.
- Back-to-back divisions:
  - DONE + `accept` → IDLE; the next instruction's `start` is seen in IDLE one cycle later.
  - Minimum issue interval is WIDTH+2 cycles.
- Operands changing during CALC/DONE are ignored.
- `rst` mid-CALC aborts identically to `annul` but also clears `result`.

## Structure

- Shared package (`defines`):
  - state encoding `DIV_IDLE/DIV_CALC/DIV_DONE`
  - existing `DIV_CONTROL`/`DIVU_CONTROL` ALU codes, used by the ALU to form `start`/`signed_div`
- Counter width `$clog2(WIDTH+1)`, local to the module.
- One natural sub-module: `div_signfix`, combinational abs/negate for operand conditioning and result fix-up, instantiated for input and output.
- The HILO write qualifier becomes `ready & hilo_write & ~is_except`.

## Test plan

- Unsigned 100 / 7, WIDTH=32 → `stall` high cycles 0..32, `ready` at cycle 33, `result` = {32'd2, 32'd14}; `accept` → IDLE.
- Signed −7 / 2 → quotient 32'hFFFFFFFD, remainder 32'hFFFFFFFF. Signed 32'h80000000 / 32'hFFFFFFFF → {0, 32'h80000000}.
- Divide by zero: unsigned 5/0 → {5, 32'hFFFFFFFF}; signed −5/0 → {32'hFFFFFFFB, 32'd1}, full latency, no hang.
- `annul` at cycle 10 of CALC → IDLE next cycle, `ready` never asserts, `result` unchanged. A following start 9/3 → {0, 3}.
- DONE with `accept` low for 5 cycles → `ready` and `result` held, `start` still high causes no relaunch. Then `accept`, then new `start` → second result correct at issue + 33.
- `rst` asserted mid-CALC → all outputs 0 next cycle. WIDTH=8 instance: 200/13 → {8'd5, 8'd15}, `ready` at cycle 9.
